sync_source_sequencer: RTL and testbench
========================================

// Module: sync_source_sequencer
// PURPOSE
//  Sequences the sync front end: selects discrete vs composite vsync, holds polarity and format
//  detectors in reset while switching, mutes sync outputs until the format is stable, then
//  publishes a latched video format to the monitor interface. Sits between the signal
//  detectors, polarity detectors and video_format_detector; all on the 50 MHz clock.
// PARAMETERS
//  RESET_CYCLES   1000      detector reset hold after a (re)start, clk cycles (20 us)
//  STABLE_CYCLES  2500000   cycles video_format must stay constant and nonzero to lock (50 ms)
//  TIMEOUT_CYCLES 10000000  max cycles in MEASURE before a retry (200 ms)
//  MAX_RETRIES    3         MEASURE timeouts tolerated before FREE; >=1
// PORTS
//  clk_50mhz_in          in   1  system clock
//  reset                 in   1  asynchronous, active-high reset
//  hsync_present         in   1  hsync signal detector output, clk-synchronous
//  discrete_vsync_present in  1  discrete vsync detector output, clk-synchronous
//  int_ext_x             in   1  requested sync source, 1=internal; any change = source change
//  video_format          in   8  live code from video_format_detector, 0 = unknown
//  vsync_sel_discrete    out  1  1 = route discrete vsync to vsync path
//  det_reset             out  1  reset to polarity and format detectors
//  sync_mute             out  1  1 = force sync outputs inactive
//  format_valid          out  1  1 = format_out is locked and valid
//  format_out            out  8  latched video format
//  state_out             out  3  IDLE=0 SETTLE=1 MEASURE=2 LOCKED=3 FREE=4
// BEHAVIOUR
//  Reset: state IDLE, vsync_sel_discrete=0, format_out=0, all counters and retries 0.
//   Outputs then: det_reset=1, sync_mute=1, format_valid=0.
//  Outputs are registered or decoded from the state register. det_reset=1 in IDLE/SETTLE.
//   sync_mute=1 except in LOCKED/FREE. format_valid=1 only in LOCKED.
//  src_change: int_ext_x differs from last cycle's value, OR discrete_vsync_present
//   != vsync_sel_discrete.
//  Entering SETTLE: vsync_sel_discrete<=discrete_vsync_present; counters cleared. The source
//   switches only while muted.
//  Priority, per cycle:
//   (1) !hsync_present in any non-IDLE state -> IDLE, retries cleared.
//   (2) src_change in SETTLE, MEASURE, LOCKED or FREE -> SETTLE. Retries cleared only from
//       LOCKED/FREE.
//   (3) The state-local rules below.
//  IDLE: hsync_present -> SETTLE.
//  SETTLE: cnt counts 0..RESET_CYCLES-1, then -> MEASURE. det_reset spans exactly RESET_CYCLES.
//  MEASURE: stab increments when video_format==previous sample and !=0, else clears.
//   tmo increments each cycle.
//   stab==STABLE_CYCLES-1 -> LOCKED; format_out<=video_format the same edge.
//   Otherwise tmo==TIMEOUT_CYCLES-1: if retries==MAX_RETRIES-1 -> FREE, else retries+1 -> SETTLE.
//   If lock and timeout fall on the same cycle, lock wins.
//  LOCKED: stab counts while video_format!=format_out, clears on a match.
//   stab==STABLE_CYCLES-1 -> SETTLE. Single-cycle glitches are ignored.
//  FREE: sync unmuted, format_valid=0, format_out holds its last value. Leaves only via (1)/(2).
//  Counters saturate-free: widths are $clog2 of the largest parameter; no wrap is reachable.
//  Async reset mid-sequence returns to the reset state immediately.
// TESTING  (RESET_CYCLES=4 STABLE_CYCLES=8 TIMEOUT_CYCLES=32 MAX_RETRIES=2)
//  Lock: hsync_present=1, video_format=0x07 constant.
//   -> det_reset high 4 cycles; LOCKED 8 cycles after MEASURE entry; format_out=0x07;
//      format_valid=1; sync_mute=0.
//  Glitch: in LOCKED, video_format=0x03 for 3 cycles.
//   -> stays LOCKED. Hold 0x03 for 8 cycles -> SETTLE, mute=1, format_valid=0.
//  Timeout: video_format toggles 0x05/0x06 every cycle.
//   -> SETTLE/MEASURE retry once, then FREE after 2nd timeout; sync_mute=0, format_valid=0.
//  Source switch: in LOCKED, raise discrete_vsync_present.
//   -> next edge SETTLE, vsync_sel_discrete=1 while muted, relock to same format.
//  Priority: same cycle hsync_present falls and int_ext_x toggles -> IDLE, retries=0.
//   Assert reset mid-MEASURE -> all outputs at reset values.

Source files
------------

// File: rtl/sync_source_sequencer.sv
// Sync front-end sequencer: picks the vsync source, holds detectors in reset while switching,
// keeps sync muted until the video format is stable, then publishes the locked format.
module sync_source_sequencer #(
  parameter int unsigned RESET_CYCLES   = 1000,
  parameter int unsigned STABLE_CYCLES  = 2500000,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       hsync_present,
  input  logic       discrete_vsync_present,
  input  logic       int_ext_x,
  input  logic [7:0] video_format,
  output logic       vsync_sel_discrete,
  output logic       det_reset,
  output logic       sync_mute,
  output logic       format_valid,
  output logic [7:0] format_out,
  output logic [2:0] state_out
);

  localparam int unsigned MaxRs     = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES
                                                                     : STABLE_CYCLES;
  localparam int unsigned MaxCycles = (MaxRs > TIMEOUT_CYCLES) ? MaxRs : TIMEOUT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned RetryW    = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

  localparam logic [CntW-1:0]   SettleLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast   = RetryW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StMeasure = 3'd2,
    StLocked  = 3'd3,
    StFree    = 3'd4
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q, stab_q, tmo_q;
  logic [RetryW-1:0] retries_q;
  logic              int_ext_q;
  logic              vsync_sel_q;
  logic [7:0]        vf_prev_q;
  logic [7:0]        format_q;

  logic src_change, drop, restart, at_stable, timeout, retry, lost_lock, enter_settle;
  logic vf_steady;

  always_comb begin
    src_change   = (int_ext_x != int_ext_q) || (discrete_vsync_present != vsync_sel_q);
    drop         = (state_q != StIdle) && !hsync_present;
    restart      = (state_q != StIdle) && src_change;
    at_stable    = (stab_q == StableLast);
    // Lock beats timeout when both land on the same cycle.
    timeout      = (state_q == StMeasure) && !at_stable && (tmo_q == TimeoutLast);
    retry        = timeout && (retries_q != RetryLast);
    lost_lock    = (state_q == StLocked) && at_stable;
    enter_settle = !drop && (restart || ((state_q == StIdle) && hsync_present) ||
                             retry || lost_lock);
    vf_steady    = (video_format == vf_prev_q) && (video_format != 8'd0);
  end

  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      retries_q   <= '0;
      int_ext_q   <= 1'b0;
      vsync_sel_q <= 1'b0;
      vf_prev_q   <= 8'd0;
      format_q    <= 8'd0;
    end else begin
      int_ext_q <= int_ext_x;
      vf_prev_q <= video_format;
      if (drop) begin
        state_q   <= StIdle;
        retries_q <= '0;
      end else if (enter_settle) begin
        // The vsync source only changes here, while outputs are muted.
        state_q     <= StSettle;
        vsync_sel_q <= discrete_vsync_present;
        cnt_q       <= '0;
        stab_q      <= '0;
        tmo_q       <= '0;
        if (restart) begin
          if ((state_q == StLocked) || (state_q == StFree)) retries_q <= '0;
        end else if (retry) begin
          retries_q <= retries_q + 1'b1;
        end
      end else begin
        unique case (state_q)
          StSettle: begin
            if (cnt_q == SettleLast) state_q <= StMeasure;
            else                     cnt_q   <= cnt_q + 1'b1;
          end
          StMeasure: begin
            if (at_stable) begin
              state_q  <= StLocked;
              format_q <= video_format;
              stab_q   <= '0;
            end else if (timeout) begin
              state_q <= StFree;
            end else begin
              tmo_q  <= tmo_q + 1'b1;
              stab_q <= vf_steady ? stab_q + 1'b1 : '0;
            end
          end
          StLocked: stab_q <= (video_format != format_q) ? stab_q + 1'b1 : '0;
          default: ;
        endcase
      end
    end
  end

  assign vsync_sel_discrete = vsync_sel_q;
  assign det_reset          = (state_q == StIdle) || (state_q == StSettle);
  assign sync_mute          = !((state_q == StLocked) || (state_q == StFree));
  assign format_valid       = (state_q == StLocked);
  assign format_out         = format_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_sync_source_sequencer.sv
// Scoreboard bench for sync_source_sequencer: directed scenarios plus randomized traffic,
// each cycle checked against a behavioural model of the sequencing rules.
module tb_sync_source_sequencer;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int TC = 32;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       reset, hs, dv, ie;
  logic [7:0] vf;
  logic       vsync_sel_discrete, det_reset, sync_mute, format_valid;
  logic [7:0] format_out;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  sync_source_sequencer #(
    .RESET_CYCLES  (RC),
    .STABLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk_50mhz_in          (clk),
    .reset                 (reset),
    .hsync_present         (hs),
    .discrete_vsync_present(dv),
    .int_ext_x             (ie),
    .video_format          (vf),
    .vsync_sel_discrete    (vsync_sel_discrete),
    .det_reset             (det_reset),
    .sync_mute             (sync_mute),
    .format_valid          (format_valid),
    .format_out            (format_out),
    .state_out             (state_out)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       sel;
    logic       dr;
    logic       mute;
    logic       valid;
    logic [7:0] fmt;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: phase codes 0..4 are IDLE, SETTLE, MEASURE, LOCKED, FREE.
  int       m_phase = 0;
  bit       m_sel = 0;
  bit [7:0] m_fmt = 0;
  bit       m_last_ie = 0;
  bit [7:0] m_last_vf = 0;
  int       m_in_settle = 0;
  int       m_in_measure = 0;
  int       m_streak = 0;
  int       m_off = 0;
  int       m_tries = 0;

  function automatic obs_t model_view();
    obs_t o;
    o.st    = 3'(m_phase);
    o.sel   = m_sel;
    o.dr    = (m_phase <= 1);
    o.mute  = !(m_phase == 3 || m_phase == 4);
    o.valid = (m_phase == 3);
    o.fmt   = m_fmt;
    return o;
  endfunction

  task automatic go_settle(input bit d);
    m_phase      = 1;
    m_sel        = d;
    m_in_settle  = 0;
    m_in_measure = 0;
    m_streak     = 0;
  endtask

  task automatic model_step(input bit r, input bit h, input bit d, input bit i,
                            input bit [7:0] v);
    bit       src;
    bit [7:0] pv;
    if (r) begin
      m_phase = 0; m_sel = 0; m_fmt = 0; m_last_ie = 0; m_last_vf = 0;
      m_in_settle = 0; m_in_measure = 0; m_streak = 0; m_off = 0; m_tries = 0;
      return;
    end
    src       = (i != m_last_ie) || (d != m_sel);
    pv        = m_last_vf;
    m_last_ie = i;
    m_last_vf = v;
    if (m_phase != 0 && !h) begin
      m_phase = 0;
      m_tries = 0;
    end else if (m_phase != 0 && src) begin
      if (m_phase >= 3) m_tries = 0;
      go_settle(d);
    end else begin
      case (m_phase)
        0: if (h) go_settle(d);
        1: begin
          m_in_settle++;
          if (m_in_settle == RC) begin
            m_phase = 2; m_in_measure = 0; m_streak = 0;
          end
        end
        2: begin
          m_in_measure++;
          if (m_streak == SC - 1) begin
            m_phase = 3; m_fmt = v; m_off = 0;
          end else if (m_in_measure == TC) begin
            if (m_tries == MR - 1) m_phase = 4;
            else begin
              m_tries++;
              go_settle(d);
            end
          end else begin
            m_streak = (v == pv && v != 0) ? m_streak + 1 : 0;
          end
        end
        3: begin
          if (m_off == SC - 1) go_settle(d);
          else m_off = (v != m_fmt) ? m_off + 1 : 0;
        end
        default: ;
      endcase
    end
  endtask

  // One stimulus cycle: drive at negedge, queue the state expected after the next posedge.
  task automatic step(input bit r, input bit h, input bit d, input bit i, input bit [7:0] v);
    @(negedge clk);
    reset = r; hs = h; dv = d; ie = i; vf = v;
    model_step(r, h, d, i, v);
    exp_q.push_back(model_view());
  endtask

  task automatic run(input int n, input bit h, input bit d, input bit i, input bit [7:0] v);
    repeat (n) step(1'b0, h, d, i, v);
  endtask

  task automatic look();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state_out, vsync_sel_discrete, det_reset, sync_mute, format_valid, format_out};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got st=%0d sel=%0b dr=%0b mute=%0b val=%0b fmt=%02h, want st=%0d sel=%0b dr=%0b mute=%0b val=%0b fmt=%02h",
                 $time, a.st, a.sel, a.dr, a.mute, a.valid, a.fmt,
                 e.st, e.sel, e.dr, e.mute, e.valid, e.fmt);
      end
    end
  end

  initial begin
    bit       r_h, r_d, r_i;
    bit [7:0] r_v;
    int       mode;
    reset = 1'b1; hs = 1'b0; dv = 1'b0; ie = 1'b0; vf = 8'd0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    look();
    chk("reset_state", int'(state_out), 0);
    chk("reset_det_reset", int'(det_reset), 1);
    chk("reset_mute", int'(sync_mute), 1);
    chk("reset_valid", int'(format_valid), 0);
    chk("reset_fmt", int'(format_out), 0);
    chk("reset_sel", int'(vsync_sel_discrete), 0);

    // Lock on a constant format.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
    look(); chk("lock_enter_settle", int'(state_out), 1);
    run(3, 1'b1, 1'b0, 1'b0, 8'h07);
    look(); chk("settle_still_reset", int'(det_reset), 1);
    run(1, 1'b1, 1'b0, 1'b0, 8'h07);
    look(); chk("measure_after_4", int'(state_out), 2);
    chk("measure_det_reset_low", int'(det_reset), 0);
    run(7, 1'b1, 1'b0, 1'b0, 8'h07);
    look(); chk("not_locked_at_7", int'(state_out), 2);
    run(1, 1'b1, 1'b0, 1'b0, 8'h07);
    look(); chk("locked_at_8", int'(state_out), 3);
    chk("lock_fmt", int'(format_out), 7);
    chk("lock_valid", int'(format_valid), 1);
    chk("lock_unmuted", int'(sync_mute), 0);

    // Short glitch is ignored; a sustained change drops the lock.
    run(3, 1'b1, 1'b0, 1'b0, 8'h03);
    look(); chk("glitch_stays_locked", int'(state_out), 3);
    run(1, 1'b1, 1'b0, 1'b0, 8'h07);
    run(7, 1'b1, 1'b0, 1'b0, 8'h03);
    look(); chk("mismatch_7_locked", int'(state_out), 3);
    run(1, 1'b1, 1'b0, 1'b0, 8'h03);
    look(); chk("mismatch_8_settle", int'(state_out), 1);
    chk("relock_muted", int'(sync_mute), 1);
    chk("relock_invalid", int'(format_valid), 0);
    run(12, 1'b1, 1'b0, 1'b0, 8'h03);
    look(); chk("relock_fmt", int'(format_out), 3);

    // Source switch while locked.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    look(); chk("switch_settle", int'(state_out), 1);
    chk("switch_sel", int'(vsync_sel_discrete), 1);
    chk("switch_muted", int'(sync_mute), 1);
    run(12, 1'b1, 1'b1, 1'b0, 8'h03);
    look(); chk("switch_relocked", int'(state_out), 3);

    // Toggling format: lose lock, retry once, then free-run.
    for (int k = 0; k < 44; k++) step(1'b0, 1'b1, 1'b1, 1'b0, k[0] ? 8'h06 : 8'h05);
    look(); chk("first_timeout_retry", int'(state_out), 1);
    for (int k = 44; k < 80; k++) step(1'b0, 1'b1, 1'b1, 1'b0, k[0] ? 8'h06 : 8'h05);
    look(); chk("second_timeout_free", int'(state_out), 4);
    chk("free_unmuted", int'(sync_mute), 0);
    chk("free_invalid", int'(format_valid), 0);
    chk("free_fmt_held", int'(format_out), 3);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, k[0] ? 8'h06 : 8'h05);
    look(); chk("free_sticky", int'(state_out), 4);

    // hsync loss outranks a source change.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h06);
    look(); chk("prio_idle", int'(state_out), 0);

    // Asynchronous reset mid-MEASURE.
    run(1, 1'b1, 1'b1, 1'b1, 8'h09);
    run(7, 1'b1, 1'b1, 1'b1, 8'h09);
    look(); chk("pre_reset_measure", int'(state_out), 2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h09);
    #1;
    chk("async_state", int'(state_out), 0);
    chk("async_sel", int'(vsync_sel_discrete), 0);
    chk("async_fmt", int'(format_out), 0);
    chk("async_mute", int'(sync_mute), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h09);

    // Randomized traffic in bursts of differing format behaviour.
    r_h = 1'b1; r_d = 1'b0; r_i = 1'b1; r_v = 8'h01; mode = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 48 == 0) mode = $urandom_range(0, 3);
      r_h = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 149) == 0) r_d = ~r_d;
      if ($urandom_range(0, 149) == 0) r_i = ~r_i;
      case (mode)
        0: if ($urandom_range(0, 31) == 0) r_v = 8'($urandom_range(0, 3));
        1: r_v = 8'($urandom_range(0, 3));
        2: r_v = (r_v == 8'h05) ? 8'h06 : 8'h05;
        default: if ($urandom_range(0, 7) == 0) r_v = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 999) == 0), r_h, r_d, r_i, r_v);
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
